// File: rtl/sdiv_16x8.sv
// Sequential signed divider: restoring shift-subtract core, one quotient bit per cycle.
// Accepts a PWL-bit dividend and an MWL-bit divisor. Quotient truncates toward zero and saturates on overflow.
module sdiv_16x8 #(
  parameter int PWL = 16,
  parameter int MWL = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [PWL-1:0] dividend_i,
  input  logic [MWL-1:0] divisor_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [MWL-1:0] quotient_o,
  output logic [MWL-1:0] remainder_o,
  output logic           ovf_o,
  output logic           div_zero_o
);
  localparam int CW = $clog2(PWL);
  localparam logic [PWL-1:0] QPOS = PWL'((1 << (MWL-1)) - 1);
  localparam logic [PWL-1:0] QNEG = PWL'(1 << (MWL-1));

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  // The dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [PWL-1:0] dvd_q;
  logic [MWL-1:0] dvs_q, rem_q, quo_q, rmd_q;
  logic [CW-1:0]  cnt_q;
  logic           sd_q, sv_q, ovf_q, dz_q;

  logic [MWL:0]   shifted;
  logic           ge;
  logic [MWL-1:0] rem_d, quo_d;
  logic           qneg, ovf_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = (divisor_i == '0) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  always_comb begin
    shifted = {rem_q, dvd_q[PWL-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_d   = ge ? MWL'(shifted - {1'b0, dvs_q}) : shifted[MWL-1:0];
    qneg    = sd_q ^ sv_q;
    ovf_d   = qneg ? (dvd_q > QNEG) : (dvd_q > QPOS);
    if (ovf_d) quo_d = qneg ? {1'b1, {(MWL-1){1'b0}}} : {1'b0, {(MWL-1){1'b1}}};
    else       quo_d = qneg ? -dvd_q[MWL-1:0] : dvd_q[MWL-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd_q <= '0; dvs_q <= '0; rem_q <= '0; cnt_q <= '0;
      sd_q  <= 1'b0; sv_q <= 1'b0;
      quo_q <= '0; rmd_q <= '0; ovf_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          dvd_q <= dividend_i[PWL-1] ? -dividend_i : dividend_i;
          dvs_q <= divisor_i[MWL-1] ? -divisor_i : divisor_i;
          sd_q  <= dividend_i[PWL-1];
          sv_q  <= divisor_i[MWL-1];
          cnt_q <= CW'(PWL-1);
          rem_q <= '0;
          dz_q  <= (divisor_i == '0);
          if (divisor_i == '0) begin
            quo_q <= '0; rmd_q <= '0; ovf_q <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[PWL-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          ovf_q <= ovf_d;
          quo_q <= quo_d;
          rmd_q <= sd_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
  assign ovf_o       = ovf_q;
  assign div_zero_o  = dz_q;
endmodule

// File: tb/tb_sdiv_16x8.sv
// Bench for sdiv_16x8: spec vectors, random model vectors, multiplier round trips,
// backpressure, busy-input and mid-calculation reset sequences.
module tb_sdiv_16x8;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, div_zero;
  logic [15:0] dividend;
  logic [7:0]  divisor, quotient, remainder;

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] q; logic [7:0] r; logic ovf; logic dz;} exp_t;
  typedef struct {logic [15:0] a; logic [7:0] b; exp_t e; int lat;} vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   tests = 0, fails = 0;

  sdiv_16x8 dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .dividend_i(dividend), .divisor_i(divisor), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .quotient_o(quotient), .remainder_o(remainder),
    .ovf_o(ovf), .div_zero_o(div_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    int   q, r;
    exp_t e;
    if (b == 8'h00) begin
      e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dz = 1'b1;
      return e;
    end
    q = int'($signed(a)) / int'($signed(b));
    r = int'($signed(a)) % int'($signed(b));
    e.dz  = 1'b0;
    e.r   = r[7:0];
    e.ovf = (q > 127) || (q < -128);
    e.q   = e.ovf ? ((q < 0) ? 8'h80 : 8'h7F) : q[7:0];
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic o, input logic z);
    exp_t e;
    e.q = q; e.r = r; e.ovf = o; e.dz = z;
    return e;
  endfunction

  task automatic add(input logic [15:0] a, input logic [7:0] b, input exp_t e, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.e = e; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Results are checked here when the consumer takes them.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else chk("result", 32'({quotient, remainder, ovf, div_zero}), 32'(sb.pop_front()));
    end
  end

  // lat = edges after the accept edge before out_valid shows (17 -> valid in cycle 18).
  task automatic run(input logic [15:0] a, input logic [7:0] b, input exp_t e,
                     input int lat, input int hold, input bit noise);
    int n;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    sb.push_back(e);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (noise && n >= 2) begin
        in_valid = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (n >= 40) begin
      chk("timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      return;
    end
    if (lat >= 0) chk("latency", 32'(n), 32'(lat));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold", 32'({in_ready, out_valid, quotient, remainder, ovf, div_zero}), 32'({1'b0, 1'b1, e}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_clear", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  x, y;
    logic [15:0] p;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", 32'({in_ready, out_valid, quotient, remainder, ovf, div_zero}), 32'({1'b1, 1'b0, 18'd0}));

    add(16'hFC18, 8'h19, mk(8'hD8, 8'h00, 1'b0, 1'b0), 17);
    add(16'h0064, 8'hF9, mk(8'hF2, 8'h02, 1'b0, 1'b0), 17);
    add(16'hFF9C, 8'h07, mk(8'hF2, 8'hFE, 1'b0, 1'b0), 17);
    add(16'hFF9C, 8'hF9, mk(8'h0E, 8'hFE, 1'b0, 1'b0), 17);
    add(16'h8000, 8'hFF, mk(8'h7F, 8'h00, 1'b1, 1'b0), 17);
    add(16'h4000, 8'h7F, mk(8'h7F, 8'h01, 1'b1, 1'b0), 17);
    add(16'h4000, 8'h80, mk(8'h80, 8'h00, 1'b0, 1'b0), 17);
    add(16'h1234, 8'h00, mk(8'h00, 8'h00, 1'b0, 1'b1), 0);
    add(16'hFF80, 8'h01, mk(8'h80, 8'h00, 1'b0, 1'b0), 17);
    add(16'h0080, 8'h01, mk(8'h7F, 8'h00, 1'b1, 1'b0), 17);
    add(16'h0005, 8'h07, mk(8'h00, 8'h05, 1'b0, 1'b0), 17);
    foreach (tbl[i]) run(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].lat, 0, 1'b0);

    // Backpressure: result and in_ready frozen while the consumer stalls.
    run(16'h0064, 8'hF9, mk(8'hF2, 8'h02, 1'b0, 1'b0), 17, 5, 1'b0);
    // Operands offered while busy must be ignored.
    run(16'hFC18, 8'h19, mk(8'hD8, 8'h00, 1'b0, 1'b0), 17, 0, 1'b1);

    // Reset during calculation discards the operation.
    dividend = 16'h1234; divisor = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("busy_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_state", 32'({in_ready, out_valid, quotient, remainder, ovf, div_zero}), 32'({1'b1, 1'b0, 18'd0}));
    run(16'hFF9C, 8'h07, mk(8'hF2, 8'hFE, 1'b0, 1'b0), 17, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      p = 16'($urandom);
      y = 8'($urandom);
      run(p, y, model(p, y), -1, 0, 1'b0);
    end

    // Round trip against multiplier products.
    for (int i = 0; i < 1500; i++) begin
      x = 8'($urandom);
      do y = 8'($urandom); while (y == 8'h00);
      p = 16'(int'($signed(x)) * int'($signed(y)));
      run(p, y, mk(x, 8'h00, 1'b0, 1'b0), -1, 0, 1'b0);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
